// File: rtl/fft8_core.sv
// rtl/fft8_core.sv - pipelined 8-point radix-2 DIT FFT with valid pipeline and frame counter
// Optional FFT8_STAGE_SCALE_EN: halve every stage output instead of saturating it.
module fft8_core #(
    parameter int DW      = 16,
    parameter int TW_FRAC = 14
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            rdy_load,
    input  logic [2*DW-1:0] x0,
    input  logic [2*DW-1:0] x1,
    input  logic [2*DW-1:0] x2,
    input  logic [2*DW-1:0] x3,
    input  logic [2*DW-1:0] x4,
    input  logic [2*DW-1:0] x5,
    input  logic [2*DW-1:0] x6,
    input  logic [2*DW-1:0] x7,
    output logic [2*DW-1:0] y0,
    output logic [2*DW-1:0] y1,
    output logic [2*DW-1:0] y2,
    output logic [2*DW-1:0] y3,
    output logic [2*DW-1:0] y4,
    output logic [2*DW-1:0] y5,
    output logic [2*DW-1:0] y6,
    output logic [2*DW-1:0] y7,
    output logic            fft_valid,
    output logic [7:0]      frame_cnt
);
    // Stage-3 sums carry a twiddled term up to ~1.41x full scale, so sums use DW+3 bits.
    localparam int IW = DW + 3;
    localparam int PW = 2 * DW + 1;
    localparam logic signed [PW-1:0] L_C    = PW'(11585);
    localparam logic signed [PW-1:0] L_HALF = PW'(2 ** (TW_FRAC - 1));
    localparam logic signed [IW-1:0] L_MAX  = IW'(2 ** (DW - 1) - 1);
    localparam logic signed [IW-1:0] L_MIN  = IW'(-(2 ** (DW - 1)));

    function automatic logic signed [DW-1:0] wre(input logic [2*DW-1:0] w);
        return w[2*DW-1:DW];
    endfunction

    function automatic logic signed [DW-1:0] wim(input logic [2*DW-1:0] w);
        return w[DW-1:0];
    endfunction

    function automatic logic signed [IW-1:0] ext(input logic signed [DW-1:0] a);
        return IW'(a);
    endfunction

    function automatic logic signed [DW-1:0] reduce(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] t;
`ifdef FFT8_STAGE_SCALE_EN
        t = v >>> 1;
`else
        t = v;
`endif
        if (t > L_MAX)      return L_MAX[DW-1:0];
        else if (t < L_MIN) return L_MIN[DW-1:0];
        else                return t[DW-1:0];
    endfunction

    function automatic logic signed [IW-1:0] rnd(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] t;
        t = (p + L_HALF) >>> TW_FRAC;
        return t[IW-1:0];
    endfunction

    // Returns {re, im} of W8^k * (a + jb); W8^2 is a swap/negate, no multiplier.
    function automatic logic [2*IW-1:0] twiddle(input int k, input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
        logic signed [PW-1:0] ac;
        logic signed [PW-1:0] bc;
        ac = PW'(a) * L_C;
        bc = PW'(b) * L_C;
        case (k)
            1:       return {rnd(ac + bc), rnd(bc - ac)};
            2:       return {ext(b), -ext(a)};
            3:       return {rnd(bc - ac), rnd(-ac - bc)};
            default: return {ext(a), ext(b)};
        endcase
    endfunction

    logic [2*DW-1:0]      w_x    [8];
    logic [2*DW-1:0]      w_in   [8];
    logic signed [DW-1:0] w_s1_re[8], w_s1_im[8], w_s2_re[8], w_s2_im[8], w_y_re[8], w_y_im[8];
    logic signed [DW-1:0] r_s1_re[8], r_s1_im[8], r_s2_re[8], r_s2_im[8], r_y_re[8], r_y_im[8];
    logic signed [IW-1:0] w_t_re, w_t_im;
    logic [2:0]           r_v;
    logic [7:0]           r_cnt;

    assign w_x = '{x0, x1, x2, x3, x4, x5, x6, x7};

    always_comb begin
        w_t_re = '0;
        w_t_im = '0;
        for (int i = 0; i < 8; i++) begin
            w_in[i] = w_x[(i % 2) * 4 + ((i / 2) % 2) * 2 + i / 4];
        end
        for (int g = 0; g < 4; g++) begin
            w_s1_re[2*g]   = reduce(ext(wre(w_in[2*g])) + ext(wre(w_in[2*g+1])));
            w_s1_re[2*g+1] = reduce(ext(wre(w_in[2*g])) - ext(wre(w_in[2*g+1])));
            w_s1_im[2*g]   = reduce(ext(wim(w_in[2*g])) + ext(wim(w_in[2*g+1])));
            w_s1_im[2*g+1] = reduce(ext(wim(w_in[2*g])) - ext(wim(w_in[2*g+1])));
        end
        for (int h = 0; h < 2; h++) begin
            for (int k = 0; k < 2; k++) begin
                {w_t_re, w_t_im} = twiddle(2 * k, r_s1_re[4*h+k+2], r_s1_im[4*h+k+2]);
                w_s2_re[4*h+k]   = reduce(ext(r_s1_re[4*h+k]) + w_t_re);
                w_s2_re[4*h+k+2] = reduce(ext(r_s1_re[4*h+k]) - w_t_re);
                w_s2_im[4*h+k]   = reduce(ext(r_s1_im[4*h+k]) + w_t_im);
                w_s2_im[4*h+k+2] = reduce(ext(r_s1_im[4*h+k]) - w_t_im);
            end
        end
        for (int k = 0; k < 4; k++) begin
            {w_t_re, w_t_im} = twiddle(k, r_s2_re[k+4], r_s2_im[k+4]);
            w_y_re[k]   = reduce(ext(r_s2_re[k]) + w_t_re);
            w_y_re[k+4] = reduce(ext(r_s2_re[k]) - w_t_re);
            w_y_im[k]   = reduce(ext(r_s2_im[k]) + w_t_im);
            w_y_im[k+4] = reduce(ext(r_s2_im[k]) - w_t_im);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                r_s1_re[i] <= '0;
                r_s1_im[i] <= '0;
                r_s2_re[i] <= '0;
                r_s2_im[i] <= '0;
                r_y_re[i]  <= '0;
                r_y_im[i]  <= '0;
            end
            r_v   <= '0;
            r_cnt <= '0;
        end else if (enable) begin
            for (int i = 0; i < 8; i++) begin
                r_s1_re[i] <= w_s1_re[i];
                r_s1_im[i] <= w_s1_im[i];
                r_s2_re[i] <= w_s2_re[i];
                r_s2_im[i] <= w_s2_im[i];
                r_y_re[i]  <= w_y_re[i];
                r_y_im[i]  <= w_y_im[i];
            end
            r_v <= {r_v[1:0], rdy_load};
            if (r_v[1]) r_cnt <= r_cnt + 8'd1;
        end
    end

    assign y0        = {r_y_re[0], r_y_im[0]};
    assign y1        = {r_y_re[1], r_y_im[1]};
    assign y2        = {r_y_re[2], r_y_im[2]};
    assign y3        = {r_y_re[3], r_y_im[3]};
    assign y4        = {r_y_re[4], r_y_im[4]};
    assign y5        = {r_y_re[5], r_y_im[5]};
    assign y6        = {r_y_re[6], r_y_im[6]};
    assign y7        = {r_y_re[7], r_y_im[7]};
    assign fft_valid = r_v[2];
    assign frame_cnt = r_cnt;
endmodule

// File: tb/tb_fft8_core.sv
// tb/tb_fft8_core.sv - directed self-checking bench for fft8_core
// Expected values follow FFT8_STAGE_SCALE_EN when it is defined.
module tb_fft8_core;
    typedef logic [7:0][31:0] frame_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b0;
    logic        rdy_load = 1'b0;
    logic [31:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0, x4 = '0, x5 = '0, x6 = '0, x7 = '0;
    logic [31:0] y0, y1, y2, y3, y4, y5, y6, y7;
    logic        fft_valid;
    logic [7:0]  frame_cnt;
    frame_t      w_y;
    int          total = 0;
    int          bad = 0;
    int          exp_cnt = 0;

    frame_t in_imp, in_alt, in_dc, in_x1, in_j2, zero_f;
    frame_t e_imp, e_alt, e_dc, e_x1, e_j2;

    always #5 clk = ~clk;

    fft8_core #(.DW(16), .TW_FRAC(14)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .rdy_load(rdy_load),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
        .fft_valid(fft_valid), .frame_cnt(frame_cnt)
    );

    assign w_y = {y7, y6, y5, y4, y3, y2, y1, y0};

    function automatic frame_t mk(input logic [31:0] a0, input logic [31:0] a1,
                                  input logic [31:0] a2, input logic [31:0] a3,
                                  input logic [31:0] a4, input logic [31:0] a5,
                                  input logic [31:0] a6, input logic [31:0] a7);
        frame_t f;
        f[0] = a0; f[1] = a1; f[2] = a2; f[3] = a3;
        f[4] = a4; f[5] = a5; f[6] = a6; f[7] = a7;
        return f;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input frame_t f);
        x0 = f[0]; x1 = f[1]; x2 = f[2]; x3 = f[3];
        x4 = f[4]; x5 = f[5]; x6 = f[6]; x7 = f[7];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input string tag, input frame_t e);
        chk({tag, " valid"}, 32'(fft_valid), 32'd1);
        for (int i = 0; i < 8; i++) chk($sformatf("%s y%0d", tag, i), w_y[i], e[i]);
        chk({tag, " cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, " valid"}, 32'(fft_valid), 32'd0);
        chk({tag, " cnt"}, 32'(frame_cnt), 32'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("%s y%0d", tag, i), w_y[i], 32'h0);
    endtask

    task automatic run_single(input string tag, input frame_t in_f, input frame_t e);
        drive(in_f);
        rdy_load = 1'b1;
        tick;
        rdy_load = 1'b0;
        drive(zero_f);
        tick;
        chk({tag, " early valid"}, 32'(fft_valid), 32'd0);
        tick;
        exp_cnt++;
        check_frame(tag, e);
    endtask

    initial begin
        zero_f = '0;
        in_imp = mk(32'h4000_0000, 0, 0, 0, 0, 0, 0, 0);
        in_alt = mk(32'h0800_0000, 32'hF800_0000, 32'h0800_0000, 32'hF800_0000,
                    32'h0800_0000, 32'hF800_0000, 32'h0800_0000, 32'hF800_0000);
        in_dc  = mk(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000,
                    32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000);
        in_x1  = mk(0, 32'h4000_0000, 0, 0, 0, 0, 0, 0);
        in_j2  = mk(0, 0, 32'h0000_4000, 0, 0, 0, 0, 0);
`ifdef FFT8_STAGE_SCALE_EN
        e_imp = mk(32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000,
                   32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000);
        e_alt = mk(0, 0, 0, 0, 32'h0800_0000, 0, 0, 0);
        e_dc  = mk(32'h1000_0000, 0, 0, 0, 0, 0, 0, 0);
        e_x1  = mk(32'h0800_0000, 32'h05A8_FA58, 32'h0000_F800, 32'hFA58_FA58,
                   32'hF800_0000, 32'hFA58_05A8, 32'h0000_0800, 32'h05A8_05A8);
        e_j2  = mk(32'h0000_0800, 32'h0800_0000, 32'h0000_F800, 32'hF800_0000,
                   32'h0000_0800, 32'h0800_0000, 32'h0000_F800, 32'hF800_0000);
`else
        e_imp = mk(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000,
                   32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
        e_alt = mk(0, 0, 0, 0, 32'h4000_0000, 0, 0, 0);
        e_dc  = mk(32'h7FFF_0000, 0, 0, 0, 0, 0, 0, 0);
        e_x1  = mk(32'h4000_0000, 32'h2D41_D2BF, 32'h0000_C000, 32'hD2BF_D2BF,
                   32'hC000_0000, 32'hD2BF_2D41, 32'h0000_4000, 32'h2D41_2D41);
        e_j2  = mk(32'h0000_4000, 32'h4000_0000, 32'h0000_C000, 32'hC000_0000,
                   32'h0000_4000, 32'h4000_0000, 32'h0000_C000, 32'hC000_0000);
`endif

        #1 reset_n = 1'b0;
        #1 check_cleared("reset");
        tick;
        reset_n = 1'b1;
        enable  = 1'b1;

        run_single("impulse", in_imp, e_imp);
        run_single("alternating", in_alt, e_alt);
        run_single("dc", in_dc, e_dc);
        run_single("x1_twiddle", in_x1, e_x1);
        run_single("j2_imag", in_j2, e_j2);

        reset_n = 1'b0;
        #1 check_cleared("reset2");
        exp_cnt = 0;
        tick;
        reset_n = 1'b1;

        // Three back-to-back frames; stall while the first sits on the output.
        drive(in_imp);
        rdy_load = 1'b1;
        tick;
        drive(in_alt);
        tick;
        chk("b2b early valid", 32'(fft_valid), 32'd0);
        drive(in_x1);
        tick;
        exp_cnt = 1;
        check_frame("b2b f0", e_imp);
        enable = 1'b0;
        drive(in_dc);
        tick;
        check_frame("stall1", e_imp);
        tick;
        check_frame("stall2", e_imp);
        enable   = 1'b1;
        rdy_load = 1'b0;
        drive(zero_f);
        tick;
        exp_cnt = 2;
        check_frame("b2b f1", e_alt);
        tick;
        exp_cnt = 3;
        check_frame("b2b f2", e_x1);
        tick;
        chk("b2b end valid", 32'(fft_valid), 32'd0);
        chk("b2b end cnt", 32'(frame_cnt), 32'd3);

        // Reset one cycle after a capture: the frame must never appear.
        drive(in_imp);
        rdy_load = 1'b1;
        tick;
        rdy_load = 1'b0;
        drive(zero_f);
        tick;
        reset_n = 1'b0;
        #1 check_cleared("midreset");
        tick;
        tick;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("post reset valid %0d", i), 32'(fft_valid), 32'd0);
            chk($sformatf("post reset cnt %0d", i), 32'(frame_cnt), 32'd0);
        end

        // 256 frames wrap the counter back to zero.
        drive(in_imp);
        rdy_load = 1'b1;
        repeat (256) tick;
        rdy_load = 1'b0;
        tick;
        chk("wrap cnt 255", 32'(frame_cnt), 32'd255);
        tick;
        chk("wrap cnt 0", 32'(frame_cnt), 32'd0);
        chk("wrap valid", 32'(fft_valid), 32'd1);
        chk("wrap y0", y0, e_imp[0]);
        tick;
        chk("wrap drain valid", 32'(fft_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
